// File: rtl/pulse_train_emitter_pkg.sv
// Shared constants and state type for the pulse train emitter.
// Duration width and default gap are common to the duration source and capture logic.
package pulse_train_emitter_pkg;

   localparam int unsigned PULSE_DURATION_SIZE = 15;
   localparam int unsigned EMITTER_GAP_DEFAULT = 8;
   localparam int unsigned DUR_W = PULSE_DURATION_SIZE + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_HIGH    = 3'd2,
      S_LOW     = 3'd3,
      S_ADVANCE = 3'd4
   } emitter_state_t;

endpackage

// File: rtl/pulse_train_emitter_if.sv
// Link between a duration source/controller (master) and the pulse train emitter (slave).
interface pulse_train_emitter_if #(
   parameter int unsigned COUNT_W = 16
);
   import pulse_train_emitter_pkg::*;

   logic               enable;
   logic [DUR_W-1:0]   duration;
   logic               next;
   logic               pulse_out;
   logic               busy;
   logic [COUNT_W-1:0] pulses_emitted;

   modport master (
      output enable,
      output duration,
      input  next,
      input  pulse_out,
      input  busy,
      input  pulses_emitted
   );

   modport slave (
      input  enable,
      input  duration,
      output next,
      output pulse_out,
      output busy,
      output pulses_emitted
   );

endinterface

// File: rtl/pulse_train_emitter.sv
// Replays a stream of durations as a pulse train: D high cycles, GAP_CYCLES low,
// then a one-cycle next strobe before the following duration is loaded.
module pulse_train_emitter
   import pulse_train_emitter_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = EMITTER_GAP_DEFAULT,
   parameter int unsigned COUNT_W    = 16
) (
   input logic                  clk,
   input logic                  rst,
   pulse_train_emitter_if.slave bus
);

   localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_CYCLES - 1);

   emitter_state_t     state, state_nxt;
   logic [DUR_W-1:0]   cnt, cnt_nxt;
   logic [COUNT_W-1:0] count, count_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      count_nxt = count;
      case (state)
         S_IDLE: begin
            if (bus.enable) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            // A zero duration skips straight to the gap without counting a pulse
            if (bus.duration != '0) begin
               cnt_nxt   = bus.duration - DUR_W'(1);
               state_nxt = S_HIGH;
            end else begin
               cnt_nxt   = GAP_LOAD;
               state_nxt = S_LOW;
            end
         end
         S_HIGH: begin
            if (cnt == '0) begin
               cnt_nxt   = GAP_LOAD;
               count_nxt = count + COUNT_W'(1);
               state_nxt = S_LOW;
            end else begin
               cnt_nxt = cnt - DUR_W'(1);
            end
         end
         S_LOW: begin
            if (cnt == '0) state_nxt = S_ADVANCE;
            else           cnt_nxt   = cnt - DUR_W'(1);
         end
         S_ADVANCE: begin
            state_nxt = bus.enable ? S_LOAD : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode the state register only, so they carry no path from inputs
   assign bus.pulse_out      = (state == S_HIGH);
   assign bus.next           = (state == S_ADVANCE);
   assign bus.busy           = (state != S_IDLE);
   assign bus.pulses_emitted = count;

endmodule

// File: tb/tb_pulse_train_emitter.sv
// Checks pulse_train_emitter against a queue-of-expected-cycles model plus
// directed width/gap/count expectations and a randomized soak.
module tb_pulse_train_emitter;
   import pulse_train_emitter_pkg::*;

   localparam int unsigned GAP = 8;
   localparam int unsigned CW  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pulse_train_emitter_if #(.COUNT_W(CW)) bus ();

   pulse_train_emitter #(.GAP_CYCLES(GAP), .COUNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Upstream duration source: index advances on next, resets to entry 0
   logic [DUR_W-1:0] seq [64];
   logic [5:0]       up_idx;
   always @(posedge clk) begin
      if (rst)           up_idx <= '0;
      else if (bus.next) up_idx <= up_idx + 6'd1;
   end
   assign bus.duration = seq[up_idx];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: a queue of expected per-cycle outputs, one entry per busy cycle
   typedef struct packed {
      logic hi;
      logic nx;
      logic last;
   } rec_t;

   rec_t          q [$];
   logic [5:0]    m_idx = '0;
   logic [CW-1:0] exp_count = '0;
   bit            m_valid = 1'b0;

   function automatic void push_seg(input int unsigned d);
      q.push_back('{hi: 1'b0, nx: 1'b0, last: 1'b0});
      for (int unsigned i = 0; i < d; i++)
         q.push_back('{hi: 1'b1, nx: 1'b0, last: (i == d - 1)});
      for (int unsigned i = 0; i < GAP; i++)
         q.push_back('{hi: 1'b0, nx: 1'b0, last: 1'b0});
      q.push_back('{hi: 1'b0, nx: 1'b1, last: 1'b0});
   endfunction

   always @(posedge clk) begin
      rec_t r;
      if (rst) begin
         q.delete();
         m_idx     = '0;
         exp_count = '0;
      end else if (q.size() == 0) begin
         if (bus.enable) push_seg(int'(seq[m_idx]));
      end else begin
         r = q.pop_front();
         if (r.last) exp_count = exp_count + 1'b1;
         if (r.nx) begin
            m_idx = m_idx + 6'd1;
            if (bus.enable) push_seg(int'(seq[m_idx]));
         end
      end
      m_valid = 1'b1;
   end

   // Per-cycle compare plus width/gap/next measurements
   int widths [$];
   int gaps [$];
   int hi_run = 0, lo_run = 0, n_next = 0;
   bit prev_hi = 1'b0, seen_fall = 1'b0;

   always @(negedge clk) begin
      if (m_valid) begin
         if (q.size() == 0) begin
            check("pulse_out", int'(bus.pulse_out), 0);
            check("next", int'(bus.next), 0);
            check("busy", int'(bus.busy), 0);
         end else begin
            check("pulse_out", int'(bus.pulse_out), int'(q[0].hi));
            check("next", int'(bus.next), int'(q[0].nx));
            check("busy", int'(bus.busy), 1);
         end
         check("pulses_emitted", int'(bus.pulses_emitted), int'(exp_count));
      end
      if (rst) begin
         hi_run = 0; lo_run = 0; prev_hi = 1'b0; seen_fall = 1'b0;
      end else begin
         if (bus.next) n_next++;
         if (bus.pulse_out) begin
            if (!prev_hi && seen_fall) gaps.push_back(lo_run);
            hi_run++;
         end else begin
            if (prev_hi) begin
               widths.push_back(hi_run);
               hi_run = 0; lo_run = 0; seen_fall = 1'b1;
            end
            lo_run++;
         end
         prev_hi = bus.pulse_out;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_meas();
      widths.delete();
      gaps.delete();
      n_next = 0;
   endtask

   task automatic reset_dut();
      bus.enable = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      clear_meas();
   endtask

   task automatic load_seq(input int a, input int b, input int c);
      for (int i = 0; i < 64; i++) seq[i] = '0;
      seq[0] = DUR_W'(a);
      seq[1] = DUR_W'(b);
      seq[2] = DUR_W'(c);
   endtask

   task automatic wait_widths(input int n, input int budget);
      int k = 0;
      while (widths.size() < n && k < budget) begin step(); k++; end
      if (widths.size() < n) check("timeout_widths", widths.size(), n);
   endtask

   task automatic wait_hi(input int n, input int budget);
      int k = 0;
      while (hi_run < n && k < budget) begin step(); k++; end
      if (hi_run < n) check("timeout_hi", hi_run, n);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (bus.busy && k < budget) begin step(); k++; end
      if (bus.busy) check("timeout_idle", 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bus.enable = 1'b0;
      for (int i = 0; i < 64; i++) seq[i] = '0;

      // Back-to-back widths and gaps
      load_seq(65, 75, 85);
      reset_dut();
      check("reset_busy", int'(bus.busy), 0);
      check("reset_count", int'(bus.pulses_emitted), 0);
      bus.enable = 1'b1;
      wait_widths(3, 400);
      check("t1_w0", widths[0], 65);
      check("t1_w1", widths[1], 75);
      check("t1_w2", widths[2], 85);
      check("t1_gap0", gaps[0], 10);
      check("t1_gap1", gaps[1], 10);
      bus.enable = 1'b0;
      wait_idle(100);
      check("t1_count", int'(bus.pulses_emitted), 3);
      check("t1_model_count", int'(exp_count), 3);

      // Long duration then short
      load_seq(4454, 10, 0);
      reset_dut();
      bus.enable = 1'b1;
      wait_widths(1, 5000);
      check("t2_w0", widths[0], 4454);
      check("t2_next_mid", n_next, 0);
      wait_widths(2, 100);
      check("t2_w1", widths[1], 10);
      check("t2_next_after", n_next, 1);
      bus.enable = 1'b0;
      wait_idle(100);
      check("t2_next_total", n_next, 2);
      check("t2_count", int'(bus.pulses_emitted), 2);

      // Zero duration skips a pulse
      load_seq(140, 0, 10);
      reset_dut();
      bus.enable = 1'b1;
      wait_widths(2, 400);
      check("t3_w0", widths[0], 140);
      check("t3_w1", widths[1], 10);
      check("t3_gap", gaps[0], 20);
      bus.enable = 1'b0;
      wait_idle(100);
      check("t3_count", int'(bus.pulses_emitted), 2);
      check("t3_next", n_next, 3);

      // Reset mid-pulse
      load_seq(65, 75, 85);
      reset_dut();
      bus.enable = 1'b1;
      wait_hi(30, 100);
      rst = 1'b1;
      step();
      check("t4_pulse", int'(bus.pulse_out), 0);
      check("t4_busy", int'(bus.busy), 0);
      check("t4_next", int'(bus.next), 0);
      check("t4_count", int'(bus.pulses_emitted), 0);
      rst = 1'b0;
      clear_meas();
      wait_widths(1, 200);
      check("t4_w0", widths[0], 65);
      bus.enable = 1'b0;
      wait_idle(100);

      // Enable dropped mid-pulse, re-enabled later
      load_seq(65, 75, 85);
      reset_dut();
      bus.enable = 1'b1;
      wait_widths(1, 200);
      wait_hi(20, 200);
      bus.enable = 1'b0;
      wait_idle(300);
      check("t5_w1", widths[1], 75);
      check("t5_next", n_next, 2);
      repeat (50) step();
      check("t5_idle", int'(bus.busy), 0);
      bus.enable = 1'b1;
      wait_widths(3, 300);
      check("t5_w2", widths[2], 85);
      check("t5_next_after", n_next, 2);
      bus.enable = 1'b0;
      wait_idle(100);

      // Enable toggled during LOW has no effect
      load_seq(30, 30, 30);
      reset_dut();
      bus.enable = 1'b1;
      wait_widths(1, 100);
      repeat (3) step();
      bus.enable = 1'b0;
      step();
      step();
      bus.enable = 1'b1;
      wait_widths(2, 100);
      check("t6_w1", widths[1], 30);
      check("t6_gap", gaps[0], 10);
      bus.enable = 1'b0;
      wait_idle(100);

      // Randomized soak with enable toggles and occasional resets
      for (int i = 0; i < 64; i++)
         seq[i] = ($urandom_range(3) == 0) ? '0 : DUR_W'($urandom_range(40, 1));
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         step();
         if ($urandom_range(19) == 0) bus.enable = ~bus.enable;
         rst = ($urandom_range(499) == 0);
      end
      rst = 1'b0;
      bus.enable = 1'b0;
      wait_idle(200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_train_emitter.md
# pulse_train_emitter

Consumes a stream of pulse durations from an upstream duration source and emits them as a single-bit pulse train. Each value becomes one high pulse of exactly that many clock cycles, followed by a fixed low gap. Between pulses the block requests the next duration over a one-cycle `next` strobe. It sits between the duration source and the pulse-capture/decoder logic, and replays a known photodiode-style waveform into that logic for bench and on-board testing.

## Interface
- `GAP_CYCLES`, default 8: low cycles after each pulse; legal range 1..2^(`PULSE_DURATION_SIZE`+1)-1.
- `COUNT_W`, default 16: width of `pulses_emitted`.
- `clk` in, 1: single clock; all state changes on its posedge.
- `rst` in, 1: synchronous, active-high reset.
- `enable` in, 1: run request.
- `duration` in, [`PULSE_DURATION_SIZE`:0]: current duration from upstream; combinational from upstream index.
- `next` out, 1: one-cycle strobe; upstream advances its index on the posedge where `next`=1.
- `pulse_out` out, 1: emitted pulse train.
- `busy` out, 1: high in any state other than IDLE.
- `pulses_emitted` out, [COUNT_W-1:0]: count of completed non-zero pulses; wraps.

## Operation
- States: IDLE, LOAD, HIGH, LOW, ADVANCE. One down-counter `cnt`, same width as `duration`.
- IDLE: if `enable`=1, go to LOAD.
- LOAD (1 cycle): sample `duration`.
  - Non-zero: `cnt`<=duration-1, go to HIGH.
  - Zero: `cnt`<=GAP_CYCLES-1, go to LOW. This skips the pulse and does not increment `pulses_emitted`.
- HIGH: if `cnt`==0, then `cnt`<=GAP_CYCLES-1, increment `pulses_emitted`, go to LOW; else decrement `cnt`.
- LOW: if `cnt`==0, go to ADVANCE; else decrement `cnt`.
- ADVANCE (1 cycle): `next`=1. Then go to LOAD if `enable`=1, else to IDLE.
- Re-enable from IDLE goes straight to LOAD and does not assert `next`. No duration is skipped or repeated across an enable drop.
- `enable` is sampled only in IDLE and ADVANCE. Deasserting it mid-pulse or mid-gap completes the current pulse, gap and ADVANCE before going to IDLE.
- `pulse_out` = (state==HIGH). `next` = (state==ADVANCE). `busy` = (state!=IDLE). All three are decoded from the state register only, so they are glitch-free and carry no combinational path from inputs.
- Arithmetic: `cnt` is unsigned, with no saturation needed since loads never exceed the width. `pulses_emitted` wraps from 2^COUNT_W-1 to 0.
- Reset at any time, including mid-pulse: next cycle state=IDLE, `cnt`=0, `pulses_emitted`=0, `pulse_out`=0, `next`=0, `busy`=0.

## Timing
- Reset values: all outputs 0.
- `enable` rises with the block in IDLE at edge e0:
  - LOAD in cycle e0+1.
  - `pulse_out` high for exactly D cycles starting e0+2.
  - Low for GAP_CYCLES cycles.
  - `next` high for 1 cycle.
  - LOAD of the next value on the following cycle.
- Steady-state period per non-zero value: D + GAP_CYCLES + 2 cycles. Per zero value: GAP_CYCLES + 2 cycles.
- LOAD always follows ADVANCE by one cycle. This gives upstream one full cycle for its index update before `duration` is sampled.
- `pulses_emitted` updates on the HIGH→LOW edge, coincident with `pulse_out` falling.

## Structure
- `PULSE_DURATION_SIZE` stays in the shared `vive_constants.v`.
- Add `EMITTER_GAP_DEFAULT` (8) there.
- State encodings are localparams inside the module, 3-bit binary.
- No sub-module; FSM and counter live in one module of roughly 150 lines.
- A top-level test wrapper instantiates the duration source and this block, with `next` and `duration` cross-connected and `clk`/`rst` shared.

## Test plan
- Upstream sequence 65,75,85; GAP_CYCLES=8; `enable` held high after reset → high widths 65,75,85 exactly; each low gap 10 cycles from fall to next rise (8 LOW + ADVANCE + LOAD); `pulses_emitted` reaches 3.
- Duration 4454, then 10 → high width 4454, then 10; no counter overflow; `next` fires exactly once per value.
- Duration 0 between 140 and 10 → no high cycles for the zero; gap before the 10-cycle pulse is 2×GAP_CYCLES+4 = 20 cycles; `pulses_emitted` advances by 2, not 3.
- `rst` asserted at cycle 30 of a 65-cycle pulse → `pulse_out`, `busy`, `next`, `pulses_emitted` all 0 on the next cycle; after release with `enable`=1, a full-width pulse from the upstream's reset value 65.
- `enable` dropped mid-pulse (cycle 20 of 75) → pulse finishes at 75 cycles; gap and one `next` follow, then IDLE. Re-enable 50 cycles later → next pulse is 85 (no skip or repeat), with no `next` before it.
- `enable` toggled only during LOW → no effect until ADVANCE.
